int_seq: RTL
============

# int_seq

Interrupt entry/return sequencer between the interrupt controller and the fetch/decode pipeline. It accepts a pending, enabled interrupt at a clean ID boundary, saves the return PC, flushes the pipeline and redirects fetch to the vector. On RETI it restores the saved PC. It supports one level of priority nesting through a 2-entry return stack, exposed as memory-mapped registers for save/restore.

## Interface
- No parameters. Stack depth is fixed at 2.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- int_occurred  in  1  enabled interrupt pending; level; source holds it until int_ack
- int_vec  in  16  vector of highest-priority pending source
- int_id  in  2  index of that source; 0 = highest priority
- stall_IM_ID  in  1  IM/ID stalled; no accept, no RETI action this cycle
- pc_ID  in  16  PC of instruction in ID; used as return address
- reti_ID  in  1  RETI decoded in ID
- mm_addr  in  16  memory-mapped address
- mm_we  in  1  memory-mapped write enable
- mm_wdata  in  16  write data
- mm_rdata  out  16  read data; 0 when address does not match
- flush  out  1  kill IM/ID contents; 1-cycle pulse
- redirect  out  1  load tgt_pc into fetch PC; 1-cycle pulse
- tgt_pc  out  16  redirect target
- int_ack  out  4  one-hot clear pulse to accepted source
- in_service  out  1  stack depth != 0

## Operation
- State machine with states IDLE, ENTER and RETURN.
- **IDLE, RETI.** If reti_ID & !stall_IM_ID:
  - depth != 0: pop top entry into tgt_reg, go to RETURN.
  - depth == 0: set sticky reti_err, stay in IDLE.
- **IDLE, interrupt accept.** accept = int_occurred & !stall_IM_ID & !reti_ID & (depth==0 | (depth==1 & int_id < top.id)).
  - On accept: push {pc_ID, int_id}, tgt_reg <= int_vec, int_ack[int_id] pulses this cycle, go to ENTER.
- **Same-cycle conflict.** RETI wins. The interrupt stays pending and is re-evaluated after RETURN.
- **Full stack.** depth==2: no accept.
- **Priority.** Equal or lower priority (int_id >= top.id) is never accepted while nested.
- **ENTER / RETURN.** flush=1, redirect=1, tgt_pc=tgt_reg for exactly one cycle, then IDLE. No accept and no RETI action in these states.
- **Register INT_EPC.**
  - Read: top.pc, or 0 if empty.
  - Write: overwrite top.pc when depth != 0; ignored when empty.
- **Register INT_STAT.**
  - Read: {depth[1:0], reti_err, 11'h0, top.id[1:0]}.
  - Write with wdata[13]=1: clears reti_err.
- **MM write vs. stack op.** An mm write in the same cycle as push/pop applies to the pre-operation top. The stack operation then proceeds.

## Timing
- Accept at cycle N → flush/redirect at N+1 → vector instruction fetched at N+2.
- RETI in ID at N (unstalled) → flush/redirect to popped PC at N+1.
- int_ack is combinational in cycle N and is a single-cycle pulse.
- Reset values: state IDLE, depth 0, reti_err 0, stack 0. All outputs 0, including mm_rdata, tgt_pc and in_service.
- Reset asserted in ENTER or RETURN: aborts immediately. No flush/redirect pulse is issued afterward.
- stall_IM_ID high holds IDLE indefinitely with no side effects. ENTER/RETURN proceed regardless of stall; flush dominates.

## Structure
- Constants in package common: INT_EPC, INT_STAT.
- Also in common: typedef enum int_seq_state_t {IDLE, ENTER, RETURN} and struct ret_entry_t {pc[15:0], id[1:0]}.
- Sub-module int_ret_stack: 2-entry LIFO with push, pop, top-write port, depth[1:0] and top outputs. Overflow and underflow are guarded by int_seq.

## Test plan
- **Basic entry/return.** int_occurred, int_id=2, int_vec=16'h0040, pc_ID=16'h0123 → int_ack=4'b0100 at N; flush/redirect with tgt_pc=16'h0040 at N+1. Later RETI → tgt_pc=16'h0123, in_service=0.
- **Nesting.** In service id 2; id 0 arrives with pc_ID=16'h0045 → accepted, depth=2. id 1 then arrives → no ack. Two RETIs return 16'h0045 then 16'h0123.
- **Stall.** int_occurred with stall_IM_ID=1 for 3 cycles → no ack, no flush. First unstalled cycle → accept.
- **Collision and underflow.**
  - RETI and int_occurred in the same cycle (depth 1) → pop only; interrupt accepted after RETURN.
  - RETI at depth 0 → INT_STAT bit13=1, no redirect. Write 16'h2000 to INT_STAT → bit clears.
- **EPC overwrite.** Depth 1; write 16'h0200 to INT_EPC → read returns 16'h0200. RETI → tgt_pc=16'h0200.
- **Reset mid-ENTER.** Assert rst in ENTER → next cycle all outputs 0, depth 0.

Source files
------------

// File: rtl/common.sv
// Shared definitions for the interrupt entry/return sequencer:
// memory-mapped register addresses, FSM state type and return-stack entry.
package common;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ID_W   = 2;
    localparam int unsigned ACK_W  = 4;

    // Memory-mapped register addresses
    localparam logic [DATA_W-1:0] INT_EPC  = 16'hFF00;
    localparam logic [DATA_W-1:0] INT_STAT = 16'hFF02;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTER  = 2'd1,
        RETURN = 2'd2
    } int_seq_state_t;

    // One saved context: return PC and the id of the source being serviced
    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [ID_W-1:0]   id;
    } ret_entry_t;

endpackage

// File: rtl/int_ret_stack.sv
// 2-entry LIFO holding interrupt return contexts.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, push_data push a new entry (caller guarantees not full)
//   pop             drop the top entry (caller guarantees not empty)
//   top_we, top_pc  overwrite the pc field of the current top (ignored when empty)
//   depth           number of valid entries (0..2)
//   top             current top entry, all-zero when empty
module int_ret_stack
    import common::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  ret_entry_t        push_data,
    input  logic              pop,
    input  logic              top_we,
    input  logic [DATA_W-1:0] top_pc,
    output logic [1:0]        depth,
    output ret_entry_t        top
);

    ret_entry_t entry0;
    ret_entry_t entry1;

    // Top-pc write targets the pre-operation top; a push/pop in the same
    // cycle then acts on top of it (a pop clears the slot it frees).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry0 <= '0;
            entry1 <= '0;
            depth  <= 2'd0;
        end else begin
            if (top_we) begin
                if (depth == 2'd1) begin
                    entry0.pc <= top_pc;
                end else if (depth == 2'd2) begin
                    entry1.pc <= top_pc;
                end
            end
            if (push) begin
                if (depth == 2'd0) begin
                    entry0 <= push_data;
                end else begin
                    entry1 <= push_data;
                end
                depth <= depth + 2'd1;
            end else if (pop) begin
                if (depth == 2'd2) begin
                    entry1 <= '0;
                end else begin
                    entry0 <= '0;
                end
                depth <= depth - 2'd1;
            end
        end
    end

    always_comb begin
        top = '0;
        if (depth == 2'd2) begin
            top = entry1;
        end else if (depth == 2'd1) begin
            top = entry0;
        end
    end

endmodule

// File: rtl/int_seq.sv
// Interrupt entry/return sequencer. Accepts a pending interrupt at a clean
// ID boundary, saves the return PC, flushes IM/ID and redirects fetch to the
// vector; on RETI restores the saved PC. One level of priority nesting.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   int_occurred/vec/id      pending interrupt from the controller
//   stall_IM_ID, pc_ID, reti_ID  pipeline status in ID
//   mm_addr/we/wdata/rdata   memory-mapped access to INT_EPC / INT_STAT
//   flush, redirect, tgt_pc  one-cycle fetch redirect
//   int_ack                  one-hot clear pulse to the accepted source (combinational)
//   in_service               return stack not empty
module int_seq
    import common::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              int_occurred,
    input  logic [DATA_W-1:0] int_vec,
    input  logic [ID_W-1:0]   int_id,
    input  logic              stall_IM_ID,
    input  logic [DATA_W-1:0] pc_ID,
    input  logic              reti_ID,
    input  logic [DATA_W-1:0] mm_addr,
    input  logic              mm_we,
    input  logic [DATA_W-1:0] mm_wdata,
    output logic [DATA_W-1:0] mm_rdata,
    output logic              flush,
    output logic              redirect,
    output logic [DATA_W-1:0] tgt_pc,
    output logic [ACK_W-1:0]  int_ack,
    output logic              in_service
);

    int_seq_state_t state;
    logic           reti_err;
    logic [1:0]     depth;
    ret_entry_t     top;
    ret_entry_t     push_data;

    logic reti_go;
    logic accept;
    logic pop;
    logic epc_hit;
    logic stat_hit;
    logic epc_we;

    // Entry/return decisions; RETI wins over a same-cycle interrupt.
    always_comb begin
        reti_go   = (state == IDLE) && reti_ID && !stall_IM_ID;
        accept    = (state == IDLE) && int_occurred && !stall_IM_ID && !reti_ID &&
                    ((depth == 2'd0) || ((depth == 2'd1) && (int_id < top.id)));
        pop       = reti_go && (depth != 2'd0);
        push_data = '{pc: pc_ID, id: int_id};
        int_ack   = '0;
        if (accept && !rst) begin
            int_ack = ACK_W'(4'b0001 << int_id);
        end
    end

    // Memory-mapped register decode
    always_comb begin
        epc_hit  = (mm_addr == INT_EPC);
        stat_hit = (mm_addr == INT_STAT);
        epc_we   = mm_we && epc_hit;
        mm_rdata = '0;
        if (epc_hit) begin
            mm_rdata = top.pc;
        end else if (stat_hit) begin
            mm_rdata = {depth, reti_err, 11'h000, top.id};
        end
    end

    assign in_service = (depth != 2'd0);

    int_ret_stack u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (push_data),
        .pop       (pop),
        .top_we    (epc_we),
        .top_pc    (mm_wdata),
        .depth     (depth),
        .top       (top)
    );

    // Sequencer FSM; tgt_pc doubles as the target register and is only
    // non-zero during the single ENTER/RETURN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            reti_err <= 1'b0;
            flush    <= 1'b0;
            redirect <= 1'b0;
            tgt_pc   <= '0;
        end else begin
            flush    <= 1'b0;
            redirect <= 1'b0;
            tgt_pc   <= '0;
            if (mm_we && stat_hit && mm_wdata[13]) begin
                reti_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (reti_go) begin
                        if (depth != 2'd0) begin
                            tgt_pc   <= top.pc;
                            flush    <= 1'b1;
                            redirect <= 1'b1;
                            state    <= RETURN;
                        end else begin
                            reti_err <= 1'b1;
                        end
                    end else if (accept) begin
                        tgt_pc   <= int_vec;
                        flush    <= 1'b1;
                        redirect <= 1'b1;
                        state    <= ENTER;
                    end
                end
                ENTER:   state <= IDLE;
                RETURN:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
